enoc_switch_allocator: RTL and testbench

Per-output wormhole switch allocator for the ENoC router. It sits directly downstream of the per-input route calculators. It consumes their one-hot output-port requests and returns one-hot grants. Each output port is locked to a single input from a packet's head flit through its tail flit. Round-robin priority between competing inputs rotates on each new allocation.

---
 rtl/enoc_alloc_pkg.sv | 19 +
 rtl/enoc_alloc_chk.sv | 19 +
 rtl/enoc_rr_arbiter.sv | 49 ++++
 rtl/enoc_switch_allocator.sv | 140 ++++++++++++++
 tb/tb_enoc_switch_allocator.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/enoc_alloc_pkg.sv
// Shared types and helpers for the ENoC wormhole switch allocator.
package enoc_alloc_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } alloc_state_e;

  localparam int ONEHOT_W = 32;

  function automatic int mod_inc(input int v, input int n);
    return (v + 32'sd1 >= n) ? 32'sd0 : v + 32'sd1;
  endfunction

  function automatic logic is_onehot(input logic [ONEHOT_W-1:0] v);
    return (v != {ONEHOT_W{1'b0}}) && ((v & (v - 32'd1)) == {ONEHOT_W{1'b0}});
  endfunction

endpackage

// File: rtl/enoc_alloc_chk.sv
// Simulation-only protocol checks on the allocator's request inputs.
module enoc_alloc_chk
  import enoc_alloc_pkg::*;
#(
  parameter int N = 7,
  parameter int M = 7
) (
  input logic                 clk,
  input logic                 reset_n,
  input logic [0:N-1][0:M-1]  i_output_req,
  input logic [0:N-1]         i_val
);

  for (genvar i = 0; i < N; i++) begin : g_chk
    a_req_onehot : assert property (@(posedge clk) disable iff (!reset_n)
      i_val[i] |-> is_onehot(ONEHOT_W'(i_output_req[i])));
  end

endmodule

// File: rtl/enoc_rr_arbiter.sv
// Round-robin arbiter for one output column; a held lock bypasses arbitration
// and simply follows the owner's flit-valid.
module enoc_rr_arbiter
  import enoc_alloc_pkg::*;
#(
  parameter int N  = 7,
  parameter int PW = 3
) (
  input  logic [0:N-1]  req_i,
  input  logic [0:N-1]  val_i,
  input  logic [PW-1:0] ptr_i,
  input  logic          lock_i,
  input  logic [PW-1:0] owner_i,
  output logic [0:N-1]  grant_o,
  output logic [PW-1:0] winner_o,
  output logic          valid_o
);

  logic [PW-1:0] idx_s;

  // Pick the first requester at or after the pointer, or the lock owner.
  always_comb begin
    grant_o  = '0;
    winner_o = '0;
    valid_o  = 1'b0;
    idx_s    = ptr_i;
    if (lock_i) begin
      winner_o         = owner_i;
      valid_o          = val_i[owner_i];
      grant_o[owner_i] = val_i[owner_i];
    end else begin
      for (int k = 0; k < N; k++) begin
        if (!valid_o && req_i[idx_s]) begin
          valid_o  = 1'b1;
          winner_o = idx_s;
        end else begin
          valid_o = valid_o;
        end
        idx_s = PW'(mod_inc(int'(idx_s), N));
      end
      if (valid_o) begin
        grant_o[winner_o] = 1'b1;
      end else begin
        grant_o = '0;
      end
    end
  end

endmodule

// File: rtl/enoc_switch_allocator.sv
// Per-output wormhole switch allocator: one round-robin arbiter and one
// IDLE/LOCKED owner FSM per output port, with zero-latency grants.
module enoc_switch_allocator
  import enoc_alloc_pkg::*;
#(
  parameter int N = 7,
  parameter int M = 7
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [0:N-1][0:M-1] i_output_req,
  input  logic [0:N-1]        i_val,
  input  logic [0:N-1]        i_tail,
  input  logic [0:M-1]        i_en,
  output logic [0:N-1][0:M-1] o_output_grant,
  output logic [0:N-1]        o_input_grant,
  output logic [0:M-1]        o_output_val
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  alloc_state_e  state_q [M];
  alloc_state_e  state_d [M];
  logic [PW-1:0] ptr_q   [M];
  logic [PW-1:0] ptr_d   [M];
  logic [PW-1:0] owner_q [M];
  logic [PW-1:0] owner_d [M];

  logic [0:M-1][0:N-1] req_col_s;
  logic [0:M-1][0:N-1] arb_grant_s;
  logic [0:M-1][PW-1:0] arb_win_s;
  logic [0:M-1]        arb_vld_s;
  logic [0:M-1]        xfer_s;

  // Column request sets; inputs with a malformed request vector are dropped.
  always_comb begin
    req_col_s = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < M; j++) begin
        req_col_s[j][i] = i_val[i] & is_onehot(ONEHOT_W'(i_output_req[i])) & i_output_req[i][j];
      end
    end
  end

  for (genvar g = 0; g < M; g++) begin : g_out
    enoc_rr_arbiter #(
      .N  (N),
      .PW (PW)
    ) u_arb (
      .req_i    (req_col_s[g]),
      .val_i    (i_val),
      .ptr_i    (ptr_q[g]),
      .lock_i   (state_q[g] == LOCKED),
      .owner_i  (owner_q[g]),
      .grant_o  (arb_grant_s[g]),
      .winner_o (arb_win_s[g]),
      .valid_o  (arb_vld_s[g])
    );
  end

  assign xfer_s = arb_vld_s & i_en;

  // Per-output lock FSM; the pointer only moves when an idle output is claimed.
  always_comb begin
    for (int j = 0; j < M; j++) begin
      state_d[j] = state_q[j];
      ptr_d[j]   = ptr_q[j];
      owner_d[j] = owner_q[j];
      case (state_q[j])
        IDLE: begin
          if (arb_vld_s[j]) begin
            ptr_d[j]   = PW'(mod_inc(int'(arb_win_s[j]), N));
            owner_d[j] = arb_win_s[j];
            if (xfer_s[j] && i_tail[arb_win_s[j]]) begin
              state_d[j] = IDLE;
            end else begin
              state_d[j] = LOCKED;
            end
          end else begin
            state_d[j] = IDLE;
          end
        end
        LOCKED: begin
          if (xfer_s[j] && i_tail[owner_q[j]]) begin
            state_d[j] = IDLE;
          end else begin
            state_d[j] = LOCKED;
          end
        end
        default: state_d[j] = IDLE;
      endcase
    end
  end

  // State, pointer and owner registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int j = 0; j < M; j++) begin
        state_q[j] <= IDLE;
        ptr_q[j]   <= '0;
        owner_q[j] <= '0;
      end
    end else begin
      for (int j = 0; j < M; j++) begin
        state_q[j] <= state_d[j];
        ptr_q[j]   <= ptr_d[j];
        owner_q[j] <= owner_d[j];
      end
    end
  end

  // Transpose column grants into the row-major matrix; reset forces all low.
  always_comb begin
    o_output_grant = '0;
    o_input_grant  = '0;
    o_output_val   = '0;
    if (reset_n) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < M; j++) begin
          o_output_grant[i][j] = arb_grant_s[j][i];
        end
        o_input_grant[i] = |o_output_grant[i];
      end
      o_output_val = xfer_s;
    end else begin
      o_output_val = '0;
    end
  end

  enoc_alloc_chk #(
    .N (N),
    .M (M)
  ) u_chk (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_output_req (i_output_req),
    .i_val        (i_val)
  );

endmodule

// File: tb/tb_enoc_switch_allocator.sv
// Directed self-checking bench for enoc_switch_allocator (N = M = 7).
module tb_enoc_switch_allocator;
  import enoc_alloc_pkg::*;

  localparam int N = 7;
  localparam int M = 7;

  logic                clk = 1'b0;
  logic                reset_n;
  logic [0:N-1][0:M-1] i_output_req;
  logic [0:N-1]        i_val;
  logic [0:N-1]        i_tail;
  logic [0:M-1]        i_en;
  logic [0:N-1][0:M-1] o_output_grant;
  logic [0:N-1]        o_input_grant;
  logic [0:M-1]        o_output_val;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  enoc_switch_allocator #(.N(N), .M(M)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .i_output_req   (i_output_req),
    .i_val          (i_val),
    .i_tail         (i_tail),
    .i_en           (i_en),
    .o_output_grant (o_output_grant),
    .o_input_grant  (o_input_grant),
    .o_output_val   (o_output_val)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_output_req = '0;
    i_val        = '0;
    i_tail       = '0;
    i_en         = '1;
  endtask

  function automatic logic [0:M-1] oh(input int j);
    logic [0:M-1] v;
    v = '0;
    v[j[2:0]] = 1'b1;
    return v;
  endfunction

  function automatic logic [0:N-1][0:M-1] grant_of(input int i, input int j);
    logic [0:N-1][0:M-1] m;
    m = '0;
    if (i >= 0) m[i[2:0]][j[2:0]] = 1'b1;
    return m;
  endfunction

  task automatic send(input int i, input int j, input logic tail);
    i_output_req[i[2:0]] = oh(j);
    i_val[i[2:0]]        = 1'b1;
    i_tail[i[2:0]]       = tail;
  endtask

  int rot_exp [4] = '{0, 3, 5, 0};
  int bp_val3 [8] = '{1, 1, 1, 1, 0, 1, 1, 0};
  int bp_val0 [8] = '{0, 1, 1, 1, 1, 1, 1, 1};
  int bp_en6  [8] = '{1, 0, 0, 0, 1, 1, 1, 1};
  int bp_tl3  [8] = '{0, 0, 0, 0, 0, 0, 1, 0};
  int bp_own  [8] = '{3, 3, 3, 3, -1, 3, 3, 0};
  int bp_ov   [8] = '{1, 0, 0, 0, 0, 1, 1, 1};

  initial begin
    clear_inputs();
    reset_n = 1'b0;
    send(2, 4, 1'b1);
    #3;
    check_eq("rst_grant",  64'(o_output_grant), 64'd0);
    check_eq("rst_igrant", 64'(o_input_grant),  64'd0);
    check_eq("rst_oval",   64'(o_output_val),   64'd0);
    check_eq("rst_ptr4",   64'(dut.ptr_q[4]),   64'd0);

    #14;
    reset_n = 1'b1;
    #2;
    check_eq("first_grant",  64'(o_output_grant), 64'(grant_of(2, 4)));
    check_eq("first_oval",   64'(o_output_val),   64'(7'b0000100));
    check_eq("first_igrant", 64'(o_input_grant),  64'(7'b0010000));
    step();
    check_eq("first_state4", 64'(dut.state_q[4]), 64'(IDLE));
    check_eq("first_ptr4",   64'(dut.ptr_q[4]),   64'd3);
    clear_inputs();

    // Three persistent single-flit requesters on output 1; pointer wraps.
    send(0, 1, 1'b1);
    send(3, 1, 1'b1);
    send(5, 1, 1'b1);
    for (int c = 0; c < 4; c++) begin
      #2;
      check_eq($sformatf("rot_grant%0d", c), 64'(o_output_grant), 64'(grant_of(rot_exp[c], 1)));
      check_eq($sformatf("rot_oval%0d", c),  64'(o_output_val),   64'(oh(1)));
      step();
    end
    clear_inputs();

    // 4-flit packet from input 1 holds output 6 against input 4.
    send(1, 6, 1'b0);
    send(4, 6, 1'b1);
    for (int c = 1; c <= 5; c++) begin
      i_tail[1] = (c == 4);
      i_val[1]  = (c <= 4);
      #2;
      check_eq($sformatf("worm_grant%0d", c), 64'(o_output_grant),
               64'((c <= 4) ? grant_of(1, 6) : grant_of(4, 6)));
      step();
    end
    clear_inputs();

    // Back-pressure and a bubble in the middle of input 3's packet.
    for (int c = 0; c < 8; c++) begin
      i_output_req[3] = oh(6);
      i_val[3]        = (bp_val3[c] != 0);
      i_tail[3]       = (bp_tl3[c] != 0);
      i_output_req[0] = oh(6);
      i_val[0]        = (bp_val0[c] != 0);
      i_tail[0]       = 1'b1;
      i_en[6]         = (bp_en6[c] != 0);
      #2;
      check_eq($sformatf("bp_grant%0d", c), 64'(o_output_grant), 64'(grant_of(bp_own[c], 6)));
      check_eq($sformatf("bp_oval%0d", c),  64'(o_output_val),   64'((bp_ov[c] != 0) ? oh(6) : 7'b0000000));
      step();
    end
    clear_inputs();

    // Two inputs to two distinct outputs in the same cycle.
    send(0, 3, 1'b1);
    send(2, 5, 1'b1);
    #2;
    check_eq("indep_grant",  64'(o_output_grant), 64'(grant_of(0, 3) | grant_of(2, 5)));
    check_eq("indep_oval",   64'(o_output_val),   64'(oh(3) | oh(5)));
    check_eq("indep_igrant", 64'(o_input_grant),  64'(7'b1010000));
    step();
    clear_inputs();

    // Reset asserted while input 1 holds output 2 after its 2nd flit.
    send(1, 2, 1'b0);
    send(5, 2, 1'b1);
    #2;
    check_eq("mid_flit1", 64'(o_output_grant), 64'(grant_of(1, 2)));
    step();
    #2;
    check_eq("mid_flit2", 64'(o_output_grant), 64'(grant_of(1, 2)));
    step();
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_grant",  64'(o_output_grant), 64'd0);
    check_eq("mid_rst_oval",   64'(o_output_val),   64'd0);
    check_eq("mid_rst_igrant", 64'(o_input_grant),  64'd0);
    check_eq("mid_rst_state2", 64'(dut.state_q[2]), 64'(IDLE));
    i_val[1] = 1'b0;
    #1;
    reset_n = 1'b1;
    #1;
    check_eq("mid_regrant", 64'(o_output_grant), 64'(grant_of(5, 2)));
    step();
    clear_inputs();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
